// File: rtl/nios_system_perf_pkg.sv
// nios_system_perf_pkg: shared constants, state encoding and address map for the perf snapshot engine
package nios_system_perf_pkg;
    localparam logic [3:0] CTR_STOP   = 4'd0;
    localparam logic [3:0] CTR_GO     = 4'd1;
    localparam logic [3:0] CTR_EVENT  = 4'd2;
    localparam int         CTR_STRIDE = 4;
    localparam int         NUM_WORDS  = 12;
    localparam logic [3:0] CSR_ADDR   = 4'd12;
    localparam int CSR_START     = 0;
    localparam int CSR_BUSY      = 0;
    localparam int CSR_DONE      = 1;
    localparam int CSR_OVERRUN   = 2;
    localparam int CSR_COUNT_LSB = 8;
    typedef enum logic [2:0] {ST_IDLE, ST_STOP, ST_READ, ST_RESUME, ST_FINISH} state_t;
    // Three used registers per four-word counter section: word k -> 4*(k/3)+(k%3)
    function automatic logic [3:0] word_addr(input logic [3:0] k);
        return 4'(CTR_STRIDE * (int'(k) / 3) + int'(k) % 3);
    endfunction
endpackage

// File: rtl/nios_system_perf_snapshot_buf.sv
// nios_system_perf_snapshot_buf: 12x32 snapshot register file, one capture write port, one registered read port
module nios_system_perf_snapshot_buf
    import nios_system_perf_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [3:0]  wr_idx,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    input  logic [3:0]  rd_idx,
    output logic [31:0] rd_data
);
    logic [31:0] r_mem [NUM_WORDS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_WORDS; i++) r_mem[i] <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en) r_mem[wr_idx] <= wr_data;
            if (rd_en) rd_data <= r_mem[rd_idx];
        end
    end
endmodule

// File: rtl/nios_system_perf_snapshot.sv
// nios_system_perf_snapshot: freezes the perf counter block, copies twelve counter words into a buffer, resumes
module nios_system_perf_snapshot
    import nios_system_perf_pkg::*;
#(
    parameter bit FREEZE = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        snap_trigger,
    input  logic [3:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic [3:0]  m_address,
    output logic        m_begintransfer,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    output logic        busy
);
    state_t      r_state;
    logic [3:0]  r_k;
    logic        r_cap_vld;
    logic [3:0]  r_cap_idx;
    logic        r_done;
    logic        r_overrun;
    logic [7:0]  r_count;
    logic [31:0] r_stat;
    logic        r_rsel;
    logic [31:0] w_buf_q;
    logic [31:0] w_status;
    logic        w_csr_wr;
    logic        w_start;
    logic        w_req;
    logic        w_idle;
    logic        w_last;
    logic        w_unused_wdata;

    assign w_csr_wr       = s_write && (s_address == CSR_ADDR);
    assign w_start        = w_csr_wr && s_writedata[CSR_START];
    assign w_req          = snap_trigger || w_start;
    assign w_idle         = (r_state == ST_IDLE);
    assign w_last         = (r_state == ST_RESUME) || (r_state == ST_FINISH);
    assign w_unused_wdata = ^s_writedata[31:3];
    assign busy           = !w_idle;
    assign m_writedata    = '0;
    assign s_readdata     = r_rsel ? w_buf_q : r_stat;

    // Master outputs decode straight from state so reset clears them immediately
    always_comb begin
        m_write         = (r_state == ST_STOP) || (r_state == ST_RESUME);
        m_begintransfer = m_write;
        m_address       = (r_state == ST_STOP)   ? CTR_STOP :
                          (r_state == ST_RESUME) ? CTR_GO :
                          (r_state == ST_READ)   ? word_addr(r_k) : '0;
    end

    always_comb begin
        w_status                              = '0;
        w_status[CSR_BUSY]                    = busy;
        w_status[CSR_DONE]                    = r_done;
        w_status[CSR_OVERRUN]                 = r_overrun;
        w_status[CSR_COUNT_LSB +: 8]          = r_count;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_k       <= '0;
            r_cap_vld <= 1'b0;
            r_cap_idx <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_count   <= '0;
            r_stat    <= '0;
            r_rsel    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_req) begin
                    r_state <= FREEZE ? ST_STOP : ST_READ;
                    r_k     <= '0;
                end
                ST_STOP: r_state <= ST_READ;
                ST_READ: begin
                    r_k <= r_k + 4'd1;
                    if (r_k == 4'(NUM_WORDS - 1)) r_state <= FREEZE ? ST_RESUME : ST_FINISH;
                end
                default: r_state <= ST_IDLE;
            endcase
            // Read data returns one cycle after the address, so capture lags by one slot
            r_cap_vld <= (r_state == ST_READ);
            r_cap_idx <= r_k;
            if (w_idle && w_req)                          r_done <= 1'b0;
            else if (w_last)                              r_done <= 1'b1;
            else if (w_csr_wr && s_writedata[CSR_DONE])   r_done <= 1'b0;
            if (!w_idle && w_req)                         r_overrun <= 1'b1;
            else if (w_csr_wr && s_writedata[CSR_OVERRUN]) r_overrun <= 1'b0;
            if (w_last) r_count <= r_count + 8'd1;
            if (s_read) begin
                r_rsel <= (s_address < CSR_ADDR);
                r_stat <= (s_address == CSR_ADDR) ? w_status : '0;
            end
        end
    end

    nios_system_perf_snapshot_buf u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (r_cap_vld),
        .wr_idx  (r_cap_idx),
        .wr_data (m_readdata),
        .rd_en   (s_read && (s_address < CSR_ADDR)),
        .rd_idx  (s_address),
        .rd_data (w_buf_q)
    );
endmodule

// File: tb/tb_nios_system_perf_snapshot.sv
// tb_nios_system_perf_snapshot: two engines (FREEZE=1 and FREEZE=0) against a behavioural perf counter block
module tb_nios_system_perf_snapshot;
    typedef struct packed {
        logic [3:0] addr;
        logic       wr;
        logic       bsy;
    } row_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        trig    [2];
    logic        s_read  [2];
    logic        s_write [2];
    logic [3:0]  s_addr  [2];
    logic [31:0] s_wd    [2];
    logic [31:0] s_rd    [2];
    logic [3:0]  m_addr  [2];
    logic        m_bt    [2];
    logic        m_wr    [2];
    logic [31:0] m_wd    [2];
    logic [31:0] m_rd    [2];
    logic        bsy     [2];

    int n_chk = 0;
    int n_err = 0;
    int m_count [2];
    bit m_done  [2];
    bit m_ovr   [2];
    logic [31:0] exp_buf [2][12];
    int amap [12] = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 12, 13, 14};
    row_t rows [2][16];

    logic [63:0] c_time [2][4];
    logic [31:0] c_evt  [2][4];
    logic        c_run  [2];
    logic        ld = 1'b0;
    logic [63:0] ld_time [4];
    logic [31:0] ld_evt  [4];

    always #5 clk = ~clk;

    nios_system_perf_snapshot #(.FREEZE(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .snap_trigger(trig[1]),
        .s_address(s_addr[1]), .s_read(s_read[1]), .s_write(s_write[1]),
        .s_writedata(s_wd[1]), .s_readdata(s_rd[1]),
        .m_address(m_addr[1]), .m_begintransfer(m_bt[1]), .m_write(m_wr[1]),
        .m_writedata(m_wd[1]), .m_readdata(m_rd[1]), .busy(bsy[1])
    );

    nios_system_perf_snapshot #(.FREEZE(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .snap_trigger(trig[0]),
        .s_address(s_addr[0]), .s_read(s_read[0]), .s_write(s_write[0]),
        .s_writedata(s_wd[0]), .s_readdata(s_rd[0]),
        .m_address(m_addr[0]), .m_begintransfer(m_bt[0]), .m_write(m_wr[0]),
        .m_writedata(m_wd[0]), .m_readdata(m_rd[0]), .busy(bsy[0])
    );

    function automatic logic [31:0] cread(int j, logic [3:0] a);
        case (a[1:0])
            2'd0:    return c_time[j][a[3:2]][31:0];
            2'd1:    return c_time[j][a[3:2]][63:32];
            2'd2:    return c_evt[j][a[3:2]];
            default: return 32'd0;
        endcase
    endfunction

    // Counter block: 64-bit time per section, stop at 0 halts all, go at 1 restarts and bumps event 0
    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            m_rd[j] <= cread(j, m_addr[j]);
            if (ld) begin
                c_run[j] <= 1'b1;
                for (int s = 0; s < 4; s++) begin
                    c_time[j][s] <= ld_time[s];
                    c_evt[j][s]  <= ld_evt[s];
                end
            end else if (m_wr[j] && m_bt[j] && m_addr[j] == 4'd0) begin
                c_run[j] <= 1'b0;
            end else if (m_wr[j] && m_bt[j] && m_addr[j] == 4'd1) begin
                c_run[j]    <= 1'b1;
                c_evt[j][0] <= c_evt[j][0] + 32'd1;
            end else if (c_run[j]) begin
                for (int s = 0; s < 4; s++) c_time[j][s] <= c_time[j][s] + 64'd1;
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic csr_rd(input int j, input logic [3:0] a, output logic [31:0] v);
        s_read[j] = 1'b1;
        s_addr[j] = a;
        tick;
        s_read[j] = 1'b0;
        v = s_rd[j];
    endtask

    task automatic csr_wr(input int j, input logic [3:0] a, input logic [31:0] d);
        s_write[j] = 1'b1;
        s_addr[j]  = a;
        s_wd[j]    = d;
        tick;
        s_write[j] = 1'b0;
    endtask

    task automatic status_chk(input int j);
        logic [31:0] v;
        csr_rd(j, 4'd12, v);
        check($sformatf("status%0d", j), v, {16'd0, 8'(m_count[j]), 5'd0, m_ovr[j], m_done[j], 1'b0});
    endtask

    task automatic load_ctrs;
        for (int s = 0; s < 4; s++) begin
            ld_time[s] = {$urandom, ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom};
            ld_evt[s]  = $urandom;
        end
        ld = 1'b1;
        tick;
        ld = 1'b0;
    endtask

    // mode: 0 trigger, 1 start write, 2 both; poke_at: cycle offset of an extra request while busy
    task automatic snap(input int j, input int mode, input int poke_at, input bit poke_start);
        logic [63:0] t0 [4];
        logic [31:0] e0 [4];
        logic [63:0] t;
        logic [31:0] v;
        int len;
        int a;
        len = (j == 1) ? 15 : 14;
        if (mode != 1) trig[j] = 1'b1;
        if (mode != 0) begin
            s_write[j] = 1'b1;
            s_addr[j]  = 4'd12;
            s_wd[j]    = 32'd1;
        end
        tick;
        trig[j]    = 1'b0;
        s_write[j] = 1'b0;
        for (int s = 0; s < 4; s++) begin
            t0[s] = c_time[j][s];
            e0[s] = c_evt[j][s];
        end
        for (int d = 1; d <= len; d++) begin
            check($sformatf("seq%0d_c%0d", j, d), {m_wd[j], m_addr[j], m_wr[j], m_bt[j], bsy[j]},
                  {32'd0, rows[j][d].addr, rows[j][d].wr, rows[j][d].wr, rows[j][d].bsy});
            if (d == 1) begin
                s_read[j] = 1'b1;
                s_addr[j] = 4'd12;
            end
            if (d == 2)
                check($sformatf("busy_status%0d", j), s_rd[j], {16'd0, 8'(m_count[j]), 5'd0, m_ovr[j], 1'b0, 1'b1});
            if (d == poke_at) begin
                if (poke_start) begin
                    s_write[j] = 1'b1;
                    s_addr[j]  = 4'd12;
                    s_wd[j]    = 32'd1;
                end else trig[j] = 1'b1;
            end
            if (d < len) begin
                tick;
                trig[j]    = 1'b0;
                s_write[j] = 1'b0;
                s_read[j]  = 1'b0;
            end
        end
        check($sformatf("evt%0d", j), c_evt[j][0], e0[0] + 32'(j));
        check($sformatf("run%0d", j), c_run[j], 1);
        for (int w = 0; w < 40 && bsy[j]; w++) tick;
        check($sformatf("idle%0d", j), bsy[j], 0);
        m_count[j] = (m_count[j] + 1) % 256;
        m_done[j]  = 1'b1;
        if (poke_at > 0) m_ovr[j] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            a = amap[k];
            t = t0[a / 4] + ((j == 1) ? 64'd0 : 64'(k));
            exp_buf[j][k] = (a % 4 == 0) ? t[31:0] : (a % 4 == 1) ? t[63:32] : e0[a / 4];
            csr_rd(j, 4'(k), v);
            check($sformatf("buf%0d_w%0d", j, k), v, exp_buf[j][k]);
        end
        status_chk(j);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        for (int j = 0; j < 2; j++) begin
            trig[j] = 1'b0; s_read[j] = 1'b0; s_write[j] = 1'b0;
            s_addr[j] = 4'd0; s_wd[j] = 32'd0;
            m_count[j] = 0; m_done[j] = 1'b0; m_ovr[j] = 1'b0;
        end
        for (int d = 1; d <= 15; d++) begin
            if (d == 1)       rows[1][d] = '{4'd0, 1'b1, 1'b1};
            else if (d <= 13) rows[1][d] = '{4'(amap[d - 2]), 1'b0, 1'b1};
            else if (d == 14) rows[1][d] = '{4'd1, 1'b1, 1'b1};
            else              rows[1][d] = '{4'd0, 1'b0, 1'b0};
            if (d <= 12)      rows[0][d] = '{4'(amap[d - 1]), 1'b0, 1'b1};
            else if (d == 13) rows[0][d] = '{4'd0, 1'b0, 1'b1};
            else              rows[0][d] = '{4'd0, 1'b0, 1'b0};
        end
        repeat (3) tick;
        for (int j = 0; j < 2; j++)
            check($sformatf("reset_out%0d", j), {s_rd[j], m_wd[j], m_addr[j], m_wr[j], m_bt[j], bsy[j]}, 0);
        reset_n = 1'b1;
        tick;
        status_chk(1);
        status_chk(0);
        load_ctrs;
        repeat (3) tick;

        snap(1, 0, 0, 0);
        snap(0, 0, 0, 0);

        snap(1, 1, 5, 1);
        csr_wr(1, 4'd12, 32'd4);
        m_ovr[1] = 1'b0;
        status_chk(1);
        csr_wr(1, 4'd12, 32'd2);
        m_done[1] = 1'b0;
        status_chk(1);

        snap(1, 2, 0, 0);
        snap(0, 2, 0, 0);

        csr_wr(0, 4'd3, 32'hDEAD_BEEF);
        csr_wr(0, 4'd13, 32'hFFFF_FFFF);
        csr_rd(0, 4'd13, v);
        check("addr13_read", v, 0);
        csr_rd(0, 4'd3, v);
        check("buf_write_ignored", v, exp_buf[0][3]);
        tick;
        check("readdata_hold", s_rd[0], exp_buf[0][3]);
        status_chk(0);

        trig[0] = 1'b1;
        trig[1] = 1'b1;
        tick;
        trig[0] = 1'b0;
        trig[1] = 1'b0;
        repeat (6) tick;
        reset_n = 1'b0;
        #1;
        for (int j = 0; j < 2; j++)
            check($sformatf("midreset%0d", j), {s_rd[j], m_wd[j], m_addr[j], m_wr[j], m_bt[j], bsy[j]}, 0);
        tick;
        reset_n = 1'b1;
        tick;
        for (int j = 0; j < 2; j++) begin
            m_count[j] = 0; m_done[j] = 1'b0; m_ovr[j] = 1'b0;
        end
        status_chk(1);
        status_chk(0);
        snap(1, 0, 0, 0);
        snap(0, 0, 0, 0);

        for (int i = 0; i < 255; i++) begin
            if ($urandom_range(0, 15) == 0) load_ctrs;
            repeat ($urandom_range(0, 2)) tick;
            snap(1, $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 14) : 0,
                 1'($urandom_range(0, 1)));
            if (m_ovr[1] && $urandom_range(0, 1) != 0) begin
                csr_wr(1, 4'd12, 32'd4);
                m_ovr[1] = 1'b0;
            end
        end
        csr_rd(1, 4'd12, v);
        check("count_wrap", v[15:8], 0);
        check("done_after_wrap", v[1], 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
